// File: rtl/jetson_link_scheduler_if.sv
// Bus bundle between jetson_link_scheduler and its requesters, link block and destinations.
// master = scheduler side, slave = environment side.
interface jetson_link_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned N_DST = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                tx_hold;
  logic                wr_en;
  logic [31:0]         wr_din;
  logic                rd_en;
  logic                rd_rdy;
  logic [31:0]         rd_dout;
  logic [N_DST-1:0]    dst_valid;
  logic [31:0]         dst_data;
  logic [N_DST-1:0]    dst_ready;
  logic [15:0]         drop_cnt;

  modport master (
    input  req_valid, req_data, tx_hold, rd_rdy, rd_dout, dst_ready,
    output req_ready, wr_en, wr_din, rd_en, dst_valid, dst_data, drop_cnt
  );

  modport slave (
    output req_valid, req_data, tx_hold, rd_rdy, rd_dout, dst_ready,
    input  req_ready, wr_en, wr_din, rd_en, dst_valid, dst_data, drop_cnt
  );
endinterface

// File: rtl/jetson_link_scheduler.sv
// Round-robin write arbiter plus tag-routed read drain for the Jetson SPI link block.
// Define JETSON_SCHED_STATS_EN to enable the saturating dropped-word counter.
module jetson_link_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned N_DST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jetson_link_scheduler_if.master lnk
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CND_W = IDX_W + 1;
  localparam int unsigned TAG_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DELIVER} state_e;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_din_q, wr_din_d;
  state_e           state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic [N_DST-1:0] dst_valid_q, dst_valid_d;
  logic [31:0]      dst_data_q, dst_data_d;

  logic [N_REQ-1:0] grant_c;
  logic             grant_any_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic [CND_W-1:0] cand_c;
  logic [31:0]      grant_data_c;
  logic [TAG_W-1:0] tag_c;
  logic             tag_ok_c;

  // First valid requester at or after rr_ptr wins; nothing is granted under tx_hold or reset.
  always_comb begin
    grant_c     = '0;
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_c = CND_W'(rr_ptr_q) + CND_W'(k);
      if (cand_c >= CND_W'(N_REQ)) cand_c = cand_c - CND_W'(N_REQ);
      if (!grant_any_c && lnk.req_valid[cand_c[IDX_W-1:0]] && !lnk.tx_hold && rst_n) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand_c[IDX_W-1:0];
      end
    end
    if (grant_any_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    grant_data_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx_c == IDX_W'(i)) grant_data_c = lnk.req_data[i*32 +: 32];
    end
  end

  always_comb begin
    wr_en_d  = grant_any_c;
    wr_din_d = wr_din_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_any_c) begin
      wr_din_d = grant_data_c;
      rr_ptr_d = (grant_idx_c == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  assign tag_c    = lnk.rd_dout[31:28];
  assign tag_ok_c = (tag_c != '0) && (32'(tag_c) <= N_DST);

  // IDLE leaves only once its rd_en has actually been driven, so the first read after reset is not skipped.
  always_comb begin
    state_d     = state_q;
    dst_valid_d = dst_valid_q;
    dst_data_d  = dst_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_en_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_IDLE;
        if (lnk.rd_rdy) begin
          dst_data_d = lnk.rd_dout;
          if (tag_ok_c) begin
            dst_valid_d = N_DST'(1) << (tag_c - TAG_W'(1));
            state_d     = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        if (|(dst_valid_q & lnk.dst_ready)) begin
          dst_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_en_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_din_q    <= '0;
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      dst_valid_q <= '0;
      dst_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_din_q    <= wr_din_d;
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
    end
  end

`ifdef JETSON_SCHED_STATS_EN
  logic        drop_c;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop_c = (state_q == S_WAIT) && lnk.rd_rdy && !tag_ok_c;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign lnk.drop_cnt = drop_cnt_q;
`else
  assign lnk.drop_cnt = 16'h0000;
`endif

  assign lnk.req_ready = grant_c;
  assign lnk.wr_en     = wr_en_q;
  assign lnk.wr_din    = wr_din_q;
  assign lnk.rd_en     = rd_en_q;
  assign lnk.dst_valid = dst_valid_q;
  assign lnk.dst_data  = dst_data_q;
endmodule
